cdb_arbiter: RTL and testbench

- Completion-bus arbiter that shares the ReorderBuffer's single result-write port among three execution-side requesters: ALU reservation station (req 0), branch unit (req 1), load/store buffer (req 2).
- Each requester writes into a private skid FIFO.
- A round-robin scheduler drains one entry per cycle onto a registered broadcast bus (cdb_*), which drives the ROB set port and the RS/LSB wake-up logic.
- A misprediction flush from the ROB discards all in-flight results.

---
 rtl/cdb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: three per-requester skid FIFOs drained round-robin onto a registered CDB (option CDB_BYPASS_EN).
// Latency: accepted at edge N, broadcast after edge N+1 (after edge N when CDB_BYPASS_EN wins from an empty FIFO).
// Backpressure: req_ready[i] drops while FIFO i is full, during a flush, or while rdy_in is low; CDB itself is never stalled.

// Generic skid FIFO with explicit occupancy count so full and empty stay distinct.
// Latency: head visible the cycle after the push edge.
// Backpressure: full is exported; the caller never pushes when full.
module cdb_fifo #(
    parameter int W         = 36,
    parameter int DEPTH_BIT = 1
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << DEPTH_BIT;

    logic [W-1:0]         mem [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr;
    logic [DEPTH_BIT-1:0] rd_ptr;
    logic [DEPTH_BIT:0]   cnt;

    assign head_dat = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign full     = (cnt == (DEPTH_BIT+1)'(DEPTH));

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (DEPTH_BIT+1)'(push_vld) - (DEPTH_BIT+1)'(pop_vld);
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_vld && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT  = 4,
    parameter int FIFO_DEPTH_BIT = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       clear_in,
    input  logic [2:0]                 req_valid,
    input  logic [3*ROB_WIDTH_BIT-1:0] req_id,
    input  logic [95:0]                req_val,
    output logic [2:0]                 req_ready,
    output logic                       cdb_valid,
    output logic [ROB_WIDTH_BIT-1:0]   cdb_id,
    output logic [31:0]                cdb_val,
    output logic [1:0]                 cdb_src
);
    localparam int EW = ROB_WIDTH_BIT + 32;

    logic [2:0]    full, empty, accept, cand, push, pop;
    logic [EW-1:0] head   [3];
    logic [EW-1:0] in_dat [3];
    logic [EW-1:0] win_dat;
    logic [1:0]    rr_ptr, win;
    logic [2:0]    idx;
    logic          found, grant;

    assign req_ready = {3{rdy_in & ~clear_in}} & ~full;
    assign accept    = req_valid & req_ready;

`ifdef CDB_BYPASS_EN
    // An accepted request on an empty FIFO competes directly with the heads.
    assign cand = ~empty | accept;
`else
    assign cand = ~empty;
`endif

    assign grant = rdy_in & ~clear_in & (|cand);

    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, rr_ptr} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && cand[idx]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pop     = 3'b000;
        push    = accept;
        win_dat = head[win];
        if (grant) begin
            if (!empty[win]) pop[win] = 1'b1;
`ifdef CDB_BYPASS_EN
            else begin
                push[win] = 1'b0;
                win_dat   = in_dat[win];
            end
`endif
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_req
        assign in_dat[i] = {req_id[i*ROB_WIDTH_BIT +: ROB_WIDTH_BIT], req_val[i*32 +: 32]};

        cdb_fifo #(
            .W         (EW),
            .DEPTH_BIT (FIFO_DEPTH_BIT)
        ) u_fifo (
            .core_clk (clk_in),
            .arst_n   (rst_n_in),
            .clr      (rdy_in & clear_in),
            .push_vld (push[i]),
            .push_dat (in_dat[i]),
            .pop_vld  (pop[i]),
            .head_dat (head[i]),
            .empty    (empty[i]),
            .full     (full[i])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr    <= 2'd0;
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
            cdb_val   <= '0;
            cdb_src   <= 2'd0;
        end else if (rdy_in) begin
            if (clear_in) begin
                cdb_valid <= 1'b0;
                rr_ptr    <= 2'd0;
            end else if (grant) begin
                cdb_valid         <= 1'b1;
                {cdb_id, cdb_val} <= win_dat;
                cdb_src           <= win;
                rr_ptr            <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, latency, rotation, fill, flush, stall, async reset.
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, clear_in;
    logic [2:0]  req_valid;
    logic [11:0] req_id;
    logic [95:0] req_val;
    logic [2:0]  req_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [31:0] cdb_val;
    logic [1:0]  cdb_src;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] val;
        logic [1:0]  src;
    } rec_t;

    rec_t mon_q[$];
    logic rdy_e;

    cdb_arbiter #(.ROB_WIDTH_BIT(4), .FIFO_DEPTH_BIT(1)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rdy_in    (rdy_in),
        .clear_in  (clear_in),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_val   (req_val),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_id    (cdb_id),
        .cdb_val   (cdb_val),
        .cdb_src   (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    // A broadcast counts once: only when rdy_in was high at the edge that produced it.
    always @(posedge clk_in) rdy_e <= rdy_in;
    always @(negedge clk_in)
        if (rst_n_in === 1'b1 && rdy_e === 1'b1 && cdb_valid === 1'b1)
            mon_q.push_back({cdb_id, cdb_val, cdb_src});

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] id, input logic [31:0] val);
        req_valid[i]         = 1'b1;
        req_id[i*4 +: 4]     = id;
        req_val[i*32 +: 32]  = val;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
        req_valid = '0; req_id = '0; req_val = '0;
        #12;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", cdb_valid); end
        checks++; if (cdb_id !== 4'd0) begin errors++; $display("FAIL reset_id got %0h exp 0", cdb_id); end
        checks++; if (cdb_val !== 32'd0) begin errors++; $display("FAIL reset_val got %0h exp 0", cdb_val); end
        checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0h exp 0", cdb_src); end
        rst_n_in = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", req_ready); end
        step();
    endtask

    task automatic test_single();
        set_req(0, 4'd5, 32'h1234);
        step();
        req_valid = '0;
`ifndef CDB_BYPASS_EN
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %0h exp 0", cdb_valid); end
        step();
`endif
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", cdb_valid); end
        checks++; if (cdb_id !== 4'd5) begin errors++; $display("FAIL single_id got %0h exp 5", cdb_id); end
        checks++; if (cdb_val !== 32'h1234) begin errors++; $display("FAIL single_val got %0h exp 1234", cdb_val); end
        checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL single_src got %0h exp 0", cdb_src); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %0h exp 0", cdb_valid); end
    endtask

    task automatic test_all_three();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        mon_q.delete();
        for (int i = 0; i < 3; i++) set_req(i, 4'(i + 1), 32'h100 + 32'(i));
        step();
        req_valid = '0;
        repeat (5) step();
        checks++; if (mon_q.size() != 3) begin errors++; $display("FAIL all3_count got %0d exp 3", mon_q.size()); end
        for (int k = 0; k < 3; k++) begin
            if (mon_q.size() > k) begin
                checks++; if (mon_q[k].id !== 4'(k + 1)) begin errors++; $display("FAIL all3_id[%0d] got %0h exp %0h", k, mon_q[k].id, k + 1); end
                checks++; if (mon_q[k].src !== 2'(k)) begin errors++; $display("FAIL all3_src[%0d] got %0h exp %0h", k, mon_q[k].src, k); end
            end
        end
        // rr_ptr back at 0: req 0 must beat req 2 on a simultaneous push.
        mon_q.delete();
        set_req(0, 4'd10, 32'hA0);
        set_req(2, 4'd12, 32'hC0);
        step();
        req_valid = '0;
        repeat (4) step();
        checks++; if (mon_q.size() != 2) begin errors++; $display("FAIL rr_count got %0d exp 2", mon_q.size()); end
        if (mon_q.size() == 2) begin
            checks++; if (mon_q[0].id !== 4'd10) begin errors++; $display("FAIL rr_first got %0h exp a", mon_q[0].id); end
            checks++; if (mon_q[1].id !== 4'd12) begin errors++; $display("FAIL rr_second got %0h exp c", mon_q[1].id); end
        end
    endtask

    task automatic test_fill();
        logic [3:0] tbl [3][3];
        int         n   [3];
        int         pos [3];
        logic [2:0] acc;
        logic       saw_drop;
        rec_t       q2[$];
        tbl = '{'{4'd1, 4'd2, 4'd0}, '{4'd3, 4'd4, 4'd0}, '{4'd7, 4'd8, 4'd9}};
        n   = '{2, 2, 3};
        pos = '{0, 0, 0};
        saw_drop = 1'b0;
        mon_q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (pos[i] < n[i]) set_req(i, tbl[i][pos[i]], 32'h200 + 32'(tbl[i][pos[i]]));
                else req_valid[i] = 1'b0;
            end
            acc = req_valid & req_ready;
            if (req_valid[2] && !req_ready[2]) saw_drop = 1'b1;
            step();
            for (int i = 0; i < 3; i++) if (acc[i]) pos[i]++;
        end
        req_valid = '0;
        repeat (6) step();
        checks++; if (pos[2] != 3) begin errors++; $display("FAIL fill_accepted got %0d exp 3", pos[2]); end
        checks++; if (saw_drop !== 1'b1) begin errors++; $display("FAIL fill_ready_drop got %0h exp 1", saw_drop); end
        checks++; if (mon_q.size() != 7) begin errors++; $display("FAIL fill_total got %0d exp 7", mon_q.size()); end
        foreach (mon_q[k]) if (mon_q[k].src == 2'd2) q2.push_back(mon_q[k]);
        checks++; if (q2.size() != 3) begin errors++; $display("FAIL fill_req2_count got %0d exp 3", q2.size()); end
        for (int k = 0; k < 3; k++) begin
            if (q2.size() > k) begin
                checks++; if (q2[k].id !== 4'(7 + k)) begin errors++; $display("FAIL fill_order[%0d] got %0h exp %0h", k, q2[k].id, 7 + k); end
                checks++; if (q2[k].val !== 32'h200 + 32'(7 + k)) begin errors++; $display("FAIL fill_val[%0d] got %0h exp %0h", k, q2[k].val, 32'h200 + 7 + k); end
            end
        end
    endtask

    task automatic test_flush();
        set_req(0, 4'd1, 32'h11);
        set_req(1, 4'd3, 32'h33);
        step();
        set_req(0, 4'd2, 32'h22);
        set_req(1, 4'd4, 32'h44);
        step();
        req_valid = '0;
        clear_in = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready_low got %b exp 000", req_ready); end
        step();
        clear_in = 1'b0;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", cdb_valid); end
        #1;
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL flush_ready got %b exp 111", req_ready); end
        mon_q.delete();
        repeat (5) step();
        checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL flush_stale got %0d exp 0", mon_q.size()); end
    endtask

    task automatic test_stall();
        set_req(0, 4'd4, 32'h44);
        set_req(1, 4'd6, 32'h66);
        step();
        req_valid = '0;
        for (int k = 0; k < 4 && cdb_valid !== 1'b1; k++) step();
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL stall_pre_valid got %0h exp 1", cdb_valid); end
        checks++; if (cdb_id !== 4'd4) begin errors++; $display("FAIL stall_pre_id got %0h exp 4", cdb_id); end
        rdy_in = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready got %b exp 000", req_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0h exp 1", k, cdb_valid); end
            checks++; if (cdb_id !== 4'd4) begin errors++; $display("FAIL stall_id[%0d] got %0h exp 4", k, cdb_id); end
            checks++; if (cdb_val !== 32'h44) begin errors++; $display("FAIL stall_val[%0d] got %0h exp 44", k, cdb_val); end
        end
        rdy_in = 1'b1;
        step();
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL resume_valid got %0h exp 1", cdb_valid); end
        checks++; if (cdb_id !== 4'd6) begin errors++; $display("FAIL resume_id got %0h exp 6", cdb_id); end
        checks++; if (cdb_src !== 2'd1) begin errors++; $display("FAIL resume_src got %0h exp 1", cdb_src); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL resume_end got %0h exp 0", cdb_valid); end
    endtask

    task automatic test_async_reset();
        set_req(0, 4'd11, 32'hB0);
        set_req(1, 4'd12, 32'hB1);
        set_req(2, 4'd13, 32'hB2);
        step();
        req_valid = '0;
        step();
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %0h exp 1", cdb_valid); end
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0h exp 0", cdb_valid); end
        checks++; if (cdb_id !== 4'd0) begin errors++; $display("FAIL arst_id got %0h exp 0", cdb_id); end
        @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL arst_ready got %b exp 111", req_ready); end
        mon_q.delete();
        repeat (5) step();
        checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL arst_empty got %0d exp 0", mon_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_three();
        test_fill();
        test_flush();
        test_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
